bitwise_pipe_nbit: RTL

Parametrised, two-stage pipelined N-bit bitwise logic unit with a valid/ready stream interface on both sides. It generalises the fixed 16-bit XOR array: it is width-configurable, selects one of eight operations per beat, and adds a running-XOR accumulate mode for checksum/parity streams. It sits between a data producer and consumer in datapath or checksum logic and absorbs consumer back-pressure without data loss.

---
 rtl/bitwise_pkg.sv | 39 +++
 rtl/bitwise_pipe_nbit_if.sv | 27 ++
 rtl/bitwise_core.sv | 21 ++
 rtl/bitwise_pipe_nbit.sv | 91 +++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared operation codes, stage-1 control payload and per-bit operation helper
// for the pipelined bitwise logic unit.
package bitwise_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_XOR     = 3'd0;
    localparam logic [OP_W-1:0] OP_XNOR    = 3'd1;
    localparam logic [OP_W-1:0] OP_AND     = 3'd2;
    localparam logic [OP_W-1:0] OP_OR      = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND    = 3'd4;
    localparam logic [OP_W-1:0] OP_NOR     = 3'd5;
    localparam logic [OP_W-1:0] OP_ACC_XOR = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS_A  = 3'd7;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic            last;
    } ctrl_t;

    // Single-bit result of one operation; PASS_A is the default arm.
    function automatic logic bit_op(input logic [OP_W-1:0] op,
                                    input logic a, input logic b, input logic acc);
        logic r;
        r = a;
        case (op)
            OP_XOR:     r = a ^ b;
            OP_XNOR:    r = ~(a ^ b);
            OP_AND:     r = a & b;
            OP_OR:      r = a | b;
            OP_NAND:    r = ~(a & b);
            OP_NOR:     r = ~(a | b);
            OP_ACC_XOR: r = acc ^ a ^ b;
            default:    r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitwise_pipe_nbit_if.sv
// Valid/ready stream bundle for bitwise_pipe_nbit: input beat side and result side.
interface bitwise_pipe_nbit_if #(parameter int unsigned N = 16);
    import bitwise_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic [OP_W-1:0] op;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    f;
    logic            parity;
    logic            out_last;

    modport master (
        output in_valid, a, b, op, in_last, out_ready,
        input  in_ready, out_valid, f, parity, out_last
    );

    modport slave (
        input  in_valid, a, b, op, in_last, out_ready,
        output in_ready, out_valid, f, parity, out_last
    );

endinterface

// File: rtl/bitwise_core.sv
// Combinational N-bit logic unit: per-bit operation select plus XOR-reduced parity.
module bitwise_core
    import bitwise_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [N-1:0]    acc,
    input  logic [OP_W-1:0] op,
    output logic [N-1:0]    f_c,
    output logic            parity_c
);

    for (genvar i = 0; i < int'(N); i++) begin : g_bit
        assign f_c[i] = bit_op(op, a[i], b[i], acc[i]);
    end

    assign parity_c = ^f_c;

endmodule

// File: rtl/bitwise_pipe_nbit.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides and a
// running-XOR accumulator that advances only when an ACC_XOR beat enters stage 2.
module bitwise_pipe_nbit
    import bitwise_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic               clk,
    input  logic               rst,
    bitwise_pipe_nbit_if.slave bus
);

    logic         s1_valid;
    logic [N-1:0] s1_a;
    logic [N-1:0] s1_b;
    ctrl_t        s1_ctrl;

    logic         out_valid_q;
    logic [N-1:0] f_q;
    logic         parity_q;
    logic         out_last_q;
    logic [N-1:0] acc_q;

    logic         s2_adv_c;
    logic         s1_adv_c;
    logic         in_ready_c;
    logic         accept_c;
    logic [N-1:0] core_f_c;
    logic         core_parity_c;

    // Stage 2 can take a beat when empty or draining; stage 1 when empty or moving on.
    assign s2_adv_c   = !out_valid_q || bus.out_ready;
    assign s1_adv_c   = s1_valid && s2_adv_c;
    assign in_ready_c = !s1_valid || s2_adv_c;
    assign accept_c   = bus.in_valid && in_ready_c;

    bitwise_core #(.N(N)) u_core (
        .a        (s1_a),
        .b        (s1_b),
        .acc      (acc_q),
        .op       (s1_ctrl.op),
        .f_c      (core_f_c),
        .parity_c (core_parity_c)
    );

    // Stage 1: operand and control capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ctrl  <= '0;
        end else if (accept_c) begin
            s1_valid     <= 1'b1;
            s1_a         <= bus.a;
            s1_b         <= bus.b;
            s1_ctrl.op   <= bus.op;
            s1_ctrl.last <= bus.in_last;
        end else if (s1_adv_c) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: result registers and accumulator; frozen while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            f_q         <= '0;
            parity_q    <= 1'b0;
            out_last_q  <= 1'b0;
            acc_q       <= '0;
        end else if (s2_adv_c) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                f_q        <= core_f_c;
                parity_q   <= core_parity_c;
                out_last_q <= s1_ctrl.last;
                if (s1_ctrl.op == OP_ACC_XOR) begin
                    acc_q <= s1_ctrl.last ? '0 : core_f_c;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.parity    = parity_q;
    assign bus.out_last  = out_last_q;

endmodule
